// File: rtl/time_base.sv
// 1 kHz time base: seconds square wave plus debounced +/- button pulses.
// Define TIME_BASE_AUTO_REPEAT_EN to add auto-repeat while a button is held.

module time_base_btn #(
    parameter int DEBOUNCE_MS = 20
`ifdef TIME_BASE_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_MS = 1000,
    parameter int REPEAT_RATE_MS  = 200
`endif
) (
    input  logic i_clk_0_001s,
    input  logic reset,
    input  logic btn_raw,
    output logic fire
);
    localparam int DBW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t         state;
    logic           btn_meta, btn_sync;
    logic [DBW-1:0] dcnt;
    logic           accept;

    always_ff @(posedge i_clk_0_001s or negedge reset)
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end

    assign accept = (state == PRESS_CHK) && btn_sync && (dcnt == DB_LAST);

    always_ff @(posedge i_clk_0_001s or negedge reset)
        if (!reset) begin
            state <= IDLE;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE:
                    if (btn_sync) begin
                        state <= PRESS_CHK;
                        dcnt  <= '0;
                    end
                PRESS_CHK:
                    if (!btn_sync)            state <= IDLE;
                    else if (dcnt == DB_LAST) state <= HELD;
                    else                      dcnt  <= dcnt + 1'b1;
                HELD:
                    if (!btn_sync) begin
                        state <= REL_CHK;
                        dcnt  <= '0;
                    end
                REL_CHK:
                    if (btn_sync)             state <= HELD;
                    else if (dcnt == DB_LAST) state <= IDLE;
                    else                      dcnt  <= dcnt + 1'b1;
                default: state <= IDLE;
            endcase
        end

`ifdef TIME_BASE_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_MS - 1);

    logic [RW-1:0] rcnt;
    logic          rep_phase;
    logic          rep_fire;

    assign rep_fire = (state == HELD) && btn_sync &&
                      (rcnt == (rep_phase ? RATE_LAST : DLY_LAST));

    // Any exit from HELD (including a bounce into REL_CHK) restarts the delay.
    always_ff @(posedge i_clk_0_001s or negedge reset)
        if (!reset) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (state != HELD || !btn_sync) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rcnt      <= '0;
            rep_phase <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end

    assign fire = accept | rep_fire;
`else
    assign fire = accept;
`endif
endmodule

module time_base #(
    parameter int PERIOD_MS       = 1000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int PULSE_MS        = 10,
    parameter int REPEAT_DELAY_MS = 1000,
    parameter int REPEAT_RATE_MS  = 200
) (
    input  logic i_clk_0_001s,
    input  logic reset,
    input  logic is_modify,
    input  logic i_btn_plus,
    input  logic i_btn_minus,
    output logic o_enable,
    output logic o_plus,
    output logic o_minus
);
    localparam int CW = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_MS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(PERIOD_MS / 2);

    // A pulse must end before the earliest possible repeat so a low gap always follows it.
    localparam int RATE_CAP = REPEAT_RATE_MS - 1;
    localparam int DLY_CAP  = REPEAT_DELAY_MS - 1;
    localparam int CAP      = (RATE_CAP < DLY_CAP) ? RATE_CAP : DLY_CAP;
    localparam int PULSE_W  = (PULSE_MS < CAP) ? PULSE_MS : CAP;
    localparam int PW       = $clog2(PULSE_W + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_W - 1);

    logic [CW-1:0] cnt, cnt_next;

    always_comb begin
        cnt_next = cnt + 1'b1;
        if (is_modify || cnt == CNT_LAST) cnt_next = '0;
    end

    always_ff @(posedge i_clk_0_001s or negedge reset)
        if (!reset) begin
            cnt      <= '0;
            o_enable <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            o_enable <= (cnt_next < CNT_HALF);
        end

    // Lane 0 = plus, lane 1 = minus.
    logic [1:0]         btn_raw, fire, start, pulse_q;
    logic [1:0][PW-1:0] pcnt;

    assign btn_raw = {i_btn_minus, i_btn_plus};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        time_base_btn #(
            .DEBOUNCE_MS    (DEBOUNCE_MS)
`ifdef TIME_BASE_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
`endif
        ) u_btn (
            .i_clk_0_001s(i_clk_0_001s),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .fire        (fire[i])
        );
    end

    // Minus wins a same-edge collision; a start during an active pulse is dropped.
    assign start[1] = fire[1] & ~pulse_q[1];
    assign start[0] = fire[0] & ~fire[1] & ~pulse_q[0];

    always_ff @(posedge i_clk_0_001s or negedge reset)
        if (!reset) begin
            pulse_q <= '0;
            pcnt    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start[i]) begin
                    pulse_q[i] <= 1'b1;
                    pcnt[i]    <= '0;
                end else if (pulse_q[i]) begin
                    if (pcnt[i] == P_LAST) pulse_q[i] <= 1'b0;
                    else                   pcnt[i]    <= pcnt[i] + 1'b1;
                end
            end
        end

    assign o_plus  = pulse_q[0];
    assign o_minus = pulse_q[1];
endmodule

// File: tb/tb_time_base.sv
// Directed bench for time_base: seconds enable, edit freeze, debounce, arbitration, reset.
module tb_time_base;
    logic i_clk_0_001s = 1'b0;
    logic reset        = 1'b1;
    logic is_modify    = 1'b0;
    logic i_btn_plus   = 1'b0;
    logic i_btn_minus  = 1'b0;
    logic o_enable, o_plus, o_minus;

    int checks = 0;
    int errors = 0;

    time_base dut (
        .i_clk_0_001s(i_clk_0_001s),
        .reset       (reset),
        .is_modify   (is_modify),
        .i_btn_plus  (i_btn_plus),
        .i_btn_minus (i_btn_minus),
        .o_enable    (o_enable),
        .o_plus      (o_plus),
        .o_minus     (o_minus)
    );

    always #5 i_clk_0_001s = ~i_clk_0_001s;

    // One rising edge, then park on the falling edge to sample and drive.
    task automatic step();
        @(posedge i_clk_0_001s);
        @(negedge i_clk_0_001s);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL reset_enable: got %b want 1", o_enable); end
        checks++; if (o_plus !== 1'b0) begin errors++; $display("FAIL reset_plus: got %b want 0", o_plus); end
        checks++; if (o_minus !== 1'b0) begin errors++; $display("FAIL reset_minus: got %b want 0", o_minus); end
        repeat (3) step();
        checks++; if (o_enable !== 1'b1) begin errors++; $display("FAIL reset_hold_enable: got %b want 1", o_enable); end
        checks++; if (o_plus !== 1'b0 || o_minus !== 1'b0) begin
            errors++; $display("FAIL reset_hold_pulses: got %b%b want 00", o_plus, o_minus);
        end
        reset = 1'b1;
    endtask

    task automatic test_enable_period();
        int falls = 0, first_fall = 0, second_fall = 0, first_rise = 0, bad = 0;
        logic prev;
        logic want;
        prev = o_enable;
        for (int k = 1; k <= 10000; k++) begin
            step();
            want = ((k % 1000) < 500);
            if (o_enable !== want) bad++;
            if (prev === 1'b1 && o_enable === 1'b0) begin
                falls++;
                if (falls == 1) first_fall = k;
                if (falls == 2) second_fall = k;
            end
            if (prev === 1'b0 && o_enable === 1'b1 && first_rise == 0) first_rise = k;
            prev = o_enable;
        end
        checks++; if (first_fall != 500) begin errors++; $display("FAIL enable_first_fall: got %0d want 500", first_fall); end
        checks++; if (first_rise != 1000) begin errors++; $display("FAIL enable_first_rise: got %0d want 1000", first_rise); end
        checks++; if (second_fall != 1500) begin errors++; $display("FAIL enable_second_fall: got %0d want 1500", second_fall); end
        checks++; if (falls != 10) begin errors++; $display("FAIL enable_fall_count: got %0d want 10", falls); end
        checks++; if (bad != 0) begin errors++; $display("FAIL enable_waveform: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_modify();
        int low_cnt = 0, first_fall = 0;
        logic prev;
        apply_reset();
        repeat (700) step();
        checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL modify_pre_enable: got %b want 0", o_enable); end
        is_modify = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (o_enable !== 1'b1) low_cnt++;
        end
        checks++; if (low_cnt != 0) begin errors++; $display("FAIL modify_freeze: %0d low cycles want 0", low_cnt); end
        is_modify = 1'b0;
        prev = o_enable;
        for (int k = 1; k <= 600; k++) begin
            step();
            if (prev === 1'b1 && o_enable === 1'b0 && first_fall == 0) first_fall = k;
            prev = o_enable;
        end
        checks++; if (first_fall != 500) begin errors++; $display("FAIL modify_resume_fall: got %0d want 500", first_fall); end
    endtask

    task automatic test_glitch();
        int hi = 0, rise = 0, width = 0, pulses = 0, hi2 = 0;
        logic prev;
        for (int r = 0; r < 10; r++) begin
            i_btn_plus = 1'b1;
            repeat (5) begin step(); if (o_plus !== 1'b0) hi++; end
            i_btn_plus = 1'b0;
            repeat (5) begin step(); if (o_plus !== 1'b0) hi++; end
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL glitch_press: %0d high cycles want 0", hi); end
        i_btn_plus = 1'b1;
        prev = o_plus;
        for (int j = 1; j <= 100; j++) begin
            step();
            if (o_plus === 1'b1 && prev === 1'b0) begin pulses++; if (rise == 0) rise = j; end
            if (o_plus === 1'b1) width++;
            prev = o_plus;
        end
        checks++; if (rise != 23) begin errors++; $display("FAIL glitch_rise_edge: got %0d want 23", rise); end
        checks++; if (width != 10) begin errors++; $display("FAIL glitch_width: got %0d want 10", width); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL glitch_pulse_count: got %0d want 1", pulses); end
        i_btn_plus = 1'b0;
        repeat (5) begin step(); if (o_plus !== 1'b0) hi2++; end
        i_btn_plus = 1'b1;
        repeat (40) begin step(); if (o_plus !== 1'b0) hi2++; end
        checks++; if (hi2 != 0) begin errors++; $display("FAIL glitch_release: %0d high cycles want 0", hi2); end
        i_btn_plus = 1'b0;
        repeat (60) step();
    endtask

    task automatic test_simultaneous();
        int plus_hi = 0, m_pulses = 0, m_rise = 0;
        logic prev;
        i_btn_plus  = 1'b1;
        i_btn_minus = 1'b1;
        prev = o_minus;
        for (int j = 1; j <= 100; j++) begin
            step();
            if (o_plus !== 1'b0) plus_hi++;
            if (o_minus === 1'b1 && prev === 1'b0) begin m_pulses++; if (m_rise == 0) m_rise = j; end
            prev = o_minus;
        end
        checks++; if (plus_hi != 0) begin errors++; $display("FAIL simul_plus_quiet: %0d high cycles want 0", plus_hi); end
        checks++; if (m_pulses != 1) begin errors++; $display("FAIL simul_minus_count: got %0d want 1", m_pulses); end
        checks++; if (m_rise != 23) begin errors++; $display("FAIL simul_minus_rise: got %0d want 23", m_rise); end
        i_btn_plus  = 1'b0;
        i_btn_minus = 1'b0;
        repeat (60) step();
    endtask

    task automatic test_hold();
        int rises[8];
        int n = 0, hi = 0;
        logic prev;
`ifdef TIME_BASE_AUTO_REPEAT_EN
        int exp_n = 6;
        int exp_at[6] = '{23, 1023, 1223, 1423, 1623, 1823};
`else
        int exp_n = 1;
        int exp_at[6] = '{23, 0, 0, 0, 0, 0};
`endif
        i_btn_minus = 1'b1;
        prev = o_minus;
        for (int j = 1; j <= 2000; j++) begin
            step();
            if (o_minus === 1'b1 && prev === 1'b0) begin
                if (n < 8) rises[n] = j;
                n++;
            end
            if (o_minus === 1'b1) hi++;
            prev = o_minus;
        end
        checks++; if (n != exp_n) begin errors++; $display("FAIL hold_pulse_count: got %0d want %0d", n, exp_n); end
        checks++; if (hi != exp_n * 10) begin errors++; $display("FAIL hold_high_cycles: got %0d want %0d", hi, exp_n * 10); end
        for (int i = 0; i < exp_n && i < n; i++) begin
            checks++;
            if (rises[i] != exp_at[i]) begin
                errors++; $display("FAIL hold_rise_%0d: got %0d want %0d", i, rises[i], exp_at[i]);
            end
        end
        i_btn_minus = 1'b0;
        repeat (60) step();
    endtask

    task automatic test_reset_mid_pulse();
        int rise = 0, rise2 = 0;
        i_btn_plus = 1'b1;
        for (int j = 1; j <= 60 && rise == 0; j++) begin
            step();
            if (o_plus === 1'b1) rise = j;
        end
        checks++; if (rise != 23) begin errors++; $display("FAIL rst_mid_first_rise: got %0d want 23", rise); end
        repeat (3) step();
        checks++; if (o_plus !== 1'b1) begin errors++; $display("FAIL rst_mid_in_pulse: got %b want 1", o_plus); end
        reset = 1'b0;
        #1;
        checks++; if (o_plus !== 1'b0 || o_enable !== 1'b1) begin
            errors++; $display("FAIL rst_mid_truncate: plus %b enable %b want 0 1", o_plus, o_enable);
        end
        @(negedge i_clk_0_001s);
        repeat (2) step();
        reset = 1'b1;
        for (int j = 1; j <= 40 && rise2 == 0; j++) begin
            step();
            if (o_plus === 1'b1) rise2 = j;
        end
        checks++; if (rise2 != 23) begin errors++; $display("FAIL rst_mid_new_rise: got %0d want 23", rise2); end
        i_btn_plus = 1'b0;
        repeat (60) step();
    endtask

    initial begin
        test_reset();
        test_enable_period();
        test_modify();
        test_glitch();
        test_simultaneous();
        test_hold();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_base.md
TIME_BASE -- requirements
Module: time_base

Interface
REQ-001 SHALL have parameter PERIOD_MS, default 1000: ms ticks per seconds-enable period.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20: cycles a raw button level must stay stable to be accepted.
REQ-003 SHALL have parameter PULSE_MS, default 10: high width of each o_plus/o_minus pulse, in cycles; PULSE_MS < REPEAT_RATE_MS.
REQ-004 SHALL have parameters REPEAT_DELAY_MS (default 1000) and REPEAT_RATE_MS (default 200): auto-repeat timing, used only under REQ-026.
REQ-005 SHALL have ports: i_clk_0_001s  in  1  1 kHz clock; reset  in  1  asynchronous, active-low.
REQ-006 SHALL have ports: is_modify  in  1  edit mode, freezes time base; i_btn_plus  in  1  raw plus button, active-high, asynchronous; i_btn_minus  in  1  raw minus button, same.
REQ-007 SHALL have ports: o_enable  out  1  seconds square wave, falling edge = one second; o_plus  out  1  clean plus pulse; o_minus  out  1  clean minus pulse.

Function
REQ-008 SHALL hold a ms counter cnt, width ceil(log2(PERIOD_MS)), counting 0..PERIOD_MS-1 and wrapping to 0.
REQ-009 SHALL drive o_enable registered: 1 while cnt < PERIOD_MS/2, else 0 -> exactly one 1->0 transition per PERIOD_MS cycles, at cnt 499->500 by default.
REQ-010 SHALL, while is_modify=1, force cnt to 0 and o_enable to 1 -> no falling edge while editing.
REQ-011 SHALL, on is_modify 1->0, resume counting from 0; first o_enable falling edge PERIOD_MS/2 cycles after the deassertion edge.
REQ-012 SHALL pass each raw button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL implement one debounce FSM per button, states IDLE, PRESS_CHK, HELD, REL_CHK, with a shared-width stability counter per button.
REQ-014 IDLE: sync=1 -> PRESS_CHK, counter cleared.
REQ-015 PRESS_CHK: sync=0 -> IDLE; sync=1 held DEBOUNCE_MS cycles -> HELD, starting one pulse.
REQ-016 HELD: sync=0 -> REL_CHK, counter cleared.
REQ-017 REL_CHK: sync=1 -> HELD, no new pulse; sync=0 held DEBOUNCE_MS cycles -> IDLE.
REQ-018 Press latency: o_plus/o_minus SHALL rise DEBOUNCE_MS+3 edges after the first edge sampling a stable raw 1 (23 by default).
REQ-019 Each pulse SHALL be high exactly PULSE_MS consecutive cycles, then low at least one cycle, so the downstream falling-edge detector sees it.
REQ-020 Glitches shorter than DEBOUNCE_MS cycles, in either direction, SHALL produce no pulse.
REQ-021 If plus and minus pulses would start on the same edge, SHALL issue only o_minus and discard the plus event.
REQ-022 Button handling SHALL be independent of is_modify; gating is done downstream.
REQ-023 All counters SHALL saturate or clear and never wrap inside a debounce or pulse window.

Reset
REQ-024 On reset=0, asynchronously: cnt=0, o_enable=1, o_plus=0, o_minus=0, both FSMs IDLE, synchronizers and all counters 0.
REQ-025 Reset mid-pulse SHALL truncate the pulse immediately; after release, a still-pressed button SHALL re-debounce from IDLE and issue a fresh pulse.

Configuration
REQ-026 With macro TIME_BASE_AUTO_REPEAT_EN defined: in HELD, after REPEAT_DELAY_MS cycles continuous hold, SHALL issue an extra pulse every REPEAT_RATE_MS cycles until leaving HELD; REL_CHK->HELD restarts the delay.
REQ-027 Without the macro: exactly one pulse per accepted press; no repeat logic is synthesized.

Verification
REQ-028 Release reset with is_modify=0 -> o_enable falls at 500 ms, rises at 1000 ms, falls again at 1500 ms; period exactly 1000 cycles over 10 s.
REQ-029 Assert is_modify at cnt=700 for 3000 cycles -> o_enable=1 throughout, no falling edge; first fall 500 cycles after deassertion.
REQ-030 i_btn_plus high 5 cycles, low 5, repeated 10 times, then steady high 100 cycles -> no pulse from the glitches; exactly one 10-cycle o_plus pulse 23 edges into the steady level.
REQ-031 Both buttons rise on the same edge, held 100 cycles -> one o_minus pulse, o_plus stays 0.
REQ-032 Hold i_btn_minus 2000 cycles: without the macro -> 1 pulse; with TIME_BASE_AUTO_REPEAT_EN -> pulses at t0, t0+1000, +1200, +1400, +1600, +1800, where t0 = acceptance edge.
REQ-033 Assert reset 4 cycles into an o_plus pulse, button still held -> o_plus 0 at once, o_enable 1; new pulse 23 edges after reset release.
